// File: rtl/tpg_pkg.sv
// tpg_pkg: shared types and colour constants for the video test pattern generator
package tpg_pkg;
  typedef enum logic [1:0] {TPG_BARS, TPG_RAMP, TPG_CHECK, TPG_SOLID} tpg_pattern_e;
  typedef enum logic {TPG_IDLE, TPG_RUN} tpg_state_e;
  localparam logic [23:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
endpackage

// File: rtl/tpg_timing.sv
// tpg_timing: raster counters, run/idle FSM and registered dv/hs/vs/frame_start/line_end framing
module tpg_timing
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP = 20,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          run,
  output logic          active,
  output logic          h_last,
  output logic          latch,
  output logic          busy_o,
  output logic          dv_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          frame_start_o,
  output logic          line_end_o
);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HA = HW'(H_ACTIVE);
  localparam logic [VW-1:0] VA = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  tpg_state_e state, state_n;
  logic frame_last;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= TPG_IDLE;
    else state <= state_n;
  // next state: start on request, stop only at the end of a complete frame
  always_comb
    state_n = (state == TPG_IDLE) ? (en_i ? TPG_RUN : TPG_IDLE)
                                  : ((frame_last && !en_i) ? TPG_IDLE : TPG_RUN);
  // FSM-derived controls
  always_comb begin
    run = state == TPG_RUN;
    busy_o = run;
    h_last = h == H_LAST;
    frame_last = run && h_last && v == V_LAST;
    latch = en_i && (!run || frame_last);
    active = run && h < HA && v < VA;
  end
  // raster counters, held at the origin while idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (!run || h_last) begin
      h <= '0;
      v <= (!run || v == V_LAST) ? '0 : v + 1'b1;
    end else
      h <= h + 1'b1;
  // framing outputs, one cycle behind the counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dv_o <= 1'b0;
      hs_o <= ~HS_POL;
      vs_o <= ~VS_POL;
      frame_start_o <= 1'b0;
      line_end_o <= 1'b0;
    end else begin
      dv_o <= active;
      hs_o <= (h >= HS0 && h < HS1) ? HS_POL : ~HS_POL;
      vs_o <= (v >= VS0 && v < VS1) ? VS_POL : ~VS_POL;
      frame_start_o <= run && h == '0 && v == '0;
      line_end_o <= dv_o && !active;
    end
endmodule

// File: rtl/video_tpg.sv
// video_tpg: test pattern source (bars/ramp/checker/solid) with raster framing; TPG_BORDER_EN adds a white 1-pixel border
module video_tpg
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP = 20,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [1:0]  pattern_i,
  input  logic [23:0] solid_rgb_i,
  output logic [23:0] rgb_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        frame_start_o,
  output logic        line_end_o,
  output logic        busy_o
);
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
  logic [HW-1:0] h, bar_cnt;
  logic [VW-1:0] v;
  logic run, active, h_last, latch, chk;
  logic [2:0] bar_idx;
  tpg_pattern_e pat_q;
  logic [23:0] solid_q, pat_rgb, pix;
  tpg_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .en_i(en_i),
    .h(h), .v(v), .run(run), .active(active), .h_last(h_last), .latch(latch),
    .busy_o(busy_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_start_o(frame_start_o), .line_end_o(line_end_o)
  );
  // pattern selection is frozen per frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pat_q <= TPG_BARS;
      solid_q <= '0;
    end else if (latch) begin
      pat_q <= tpg_pattern_e'(pattern_i);
      solid_q <= solid_rgb_i;
    end
  // bar index from a run-length counter; saturating index lets the last bar absorb the remainder
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!run || h_last) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt <= '0;
      bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
    end else
      bar_cnt <= bar_cnt + 1'b1;
  // pattern datapath
  always_comb begin
    chk = |(((32'(h) ^ 32'(v)) >> 5) & 32'd1);
    pat_rgb = (pat_q == TPG_BARS)  ? BAR_COLORS[bar_idx] :
              (pat_q == TPG_RAMP)  ? {3{8'(h)}} :
              (pat_q == TPG_CHECK) ? {24{chk}} : solid_q;
`ifdef TPG_BORDER_EN
    pix = (h == '0 || h == HW'(H_ACTIVE - 1) || v == '0 || v == VW'(V_ACTIVE - 1)) ? 24'hFFFFFF : pat_rgb;
`else
    pix = pat_rgb;
`endif
  end
  // pixel output register, aligned with the framing registers
  always_ff @(posedge clk or posedge rst)
    if (rst) rgb_o <= '0;
    else rgb_o <= active ? pix : 24'h0;
endmodule

// File: tb/tb_video_tpg.sv
// tb_video_tpg: scoreboard bench for video_tpg with a 24x8 raster
module tb_video_tpg;
  typedef struct packed {
    logic [23:0] rgb;
    logic dv, hs, vs, fs, le;
  } obs_t;
  logic clk, rst, en_i;
  logic [1:0] pattern_i;
  logic [23:0] solid_rgb_i, rgb_o;
  logic dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o;
  obs_t sb [$];
  int n_cmp, n_err;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  video_tpg #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .pattern_i(pattern_i), .solid_rgb_i(solid_rgb_i),
    .rgb_o(rgb_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_start_o(frame_start_o), .line_end_o(line_end_o), .busy_o(busy_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t model(input logic [1:0] p, input logic [23:0] s, input int k);
    int h = k % 24;
    int v = (k / 24) % 8;
    logic [23:0] c;
    obs_t o;
    o.dv = h < 16 && v < 4;
    o.hs = h >= 18 && h < 21;
    o.vs = v >= 5 && v < 7;
    o.fs = h == 0 && v == 0;
    o.le = h == 16 && v < 4;
    case (p)
      2'd0: c = bars[h / 2];
      2'd1: c = {3{8'(h)}};
      2'd2: c = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      default: c = s;
    endcase
`ifdef TPG_BORDER_EN
    if (h == 0 || h == 15 || v == 0 || v == 3) c = 24'hFFFFFF;
`endif
    o.rgb = o.dv ? c : 24'h0;
    return o;
  endfunction

  task automatic run_frame(input logic [1:0] p, input logic [23:0] s, input int kc,
                           input logic [1:0] pn, input logic en_n);
    obs_t e, a;
    for (int k = 0; k < 192; k++) sb.push_back(model(p, s, k));
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      a = {rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL frame p=%0d k=%0d got rgb=%h dv/hs/vs/fs/le=%b%b%b%b%b required rgb=%h %b%b%b%b%b",
                 p, k, a.rgb, a.dv, a.hs, a.vs, a.fs, a.le, e.rgb, e.dv, e.hs, e.vs, e.fs, e.le);
      end
      if (k < 191) begin
        n_cmp++;
        if (busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL busy k=%0d got %b required 1", k, busy_o);
        end
      end
      if (k == kc) begin
        pattern_i = pn;
        en_i = en_n;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en_i = 1'b1;
    pattern_i = 2'd0;
    solid_rgb_i = 24'h123456;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o} !== 30'h0) begin
      n_err++;
      $display("FAIL reset got rgb=%h dv=%b hs=%b vs=%b fs=%b le=%b busy=%b required all 0",
               rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o);
    end
  endtask

  task automatic test_start;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dv_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency got dv=%b busy=%b required dv=0 busy=1", dv_o, busy_o);
    end
    @(posedge clk);
  endtask

  task automatic test_bars;
    run_frame(2'd0, 24'h0, -1, 2'd0, 1'b1);
    run_frame(2'd0, 24'h0, 100, 2'd3, 1'b1);
  endtask

  task automatic test_pattern_switch;
    run_frame(2'd3, 24'h123456, 60, 2'd1, 1'b1);
    run_frame(2'd1, 24'h123456, -1, 2'd1, 1'b1);
  endtask

  task automatic test_en_drop;
    run_frame(2'd1, 24'h123456, 30, 2'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o} !== 30'h0) begin
        n_err++;
        $display("FAIL idle i=%0d got rgb=%h dv=%b hs=%b vs=%b fs=%b le=%b busy=%b required all 0",
                 i, rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o);
      end
    end
  endtask

  task automatic test_async_reset;
    obs_t e;
    pattern_i = 2'd2;
    en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    for (int k = 0; k < 30; k++) @(negedge clk);
    e = model(2'd2, 24'h0, 29);
    n_cmp++;
    if (dv_o !== 1'b1 || rgb_o !== e.rgb) begin
      n_err++;
      $display("FAIL pre_reset got dv=%b rgb=%h required dv=1 rgb=%h", dv_o, rgb_o, e.rgb);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o} !== 30'h0) begin
      n_err++;
      $display("FAIL async_reset got rgb=%h dv=%b hs=%b vs=%b fs=%b le=%b busy=%b required all 0",
               rgb_o, dv_o, hs_o, vs_o, frame_start_o, line_end_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dv_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL restart_latency got dv=%b busy=%b required dv=0 busy=1", dv_o, busy_o);
    end
    @(posedge clk);
    run_frame(2'd2, 24'h0, -1, 2'd2, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_start;
    test_bars;
    test_pattern_switch;
    test_en_drop;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/video_tpg.md
Name: video_tpg

Overview:
- Video source/timing generator: produces the 24-bit RGB pixel stream with dv/hs/vs framing that the luma-conversion stage consumes.
- Drives the conversion stage in place of camera/HDMI input, for bring-up, display test and closed-loop verification.
- Generates raster timing from parameterised counters and fills active video with one of four selectable test patterns.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- HS_POL, 1, hs_o active level
- VS_POL, 1, vs_o active level

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- en_i  in  1  run request
- pattern_i  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
- solid_rgb_i  in  24  {r,g,b} colour for pattern 3
- rgb_o  out  24  {r[23:16],g[15:8],b[7:0]}, 0 outside active video
- dv_o  out  1  data valid
- hs_o  out  1  horizontal sync
- vs_o  out  1  vertical sync
- frame_start_o  out  1  pulse coincident with first active pixel of frame
- line_end_o  out  1  pulse in first cycle dv_o low after being high
- busy_o  out  1  high while state != IDLE

Behaviour:
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. Counter widths are $clog2 of the totals.
- Line order: active, FP, sync, BP. Frame order: same.
- Reset (async, any time, including mid-frame): state IDLE, counters 0.
  - rgb_o=0, dv_o=0, frame_start_o=0, line_end_o=0, busy_o=0.
  - hs_o=~HS_POL, vs_o=~VS_POL.
- FSM IDLE: on en_i=1 at an edge go to RUN with h=v=0 and latch pattern_i/solid_rgb_i.
- FSM RUN: h increments each clock; at h=H_TOTAL-1, h wraps to 0 and v increments.
  - At h=H_TOTAL-1, v=V_TOTAL-1: if en_i=1, wrap to (0,0) and re-latch pattern/solid; else go to IDLE.
  - en_i dropping mid-frame never truncates a frame.
- Outputs are registered: one cycle after counter state.
  - dv = h<H_ACTIVE && v<V_ACTIVE.
  - hs active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line.
  - vs active for entire lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- First dv_o high exactly 2 clock edges after en_i is first sampled high in IDLE.
- frame_start_o = registered (RUN && h==0 && v==0).
- line_end_o high in the cycle where dv_o falls (same alignment as the luma stage).
- Patterns apply to active pixels only:
  - Bars: BAR_W = H_ACTIVE/8 (integer). Order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bars: the bar index uses a run counter, not a divider; it saturates at 7, so the last bar absorbs any remainder.
  - Ramp: r=g=b=h[7:0], wrapping every 256 pixels.
  - Checker: white if h[5]^v[5], else black (32x32 squares).
  - Solid: latched solid_rgb_i.
- Pattern changes mid-frame take effect only at the next frame.

Optional Feature:
- Macro TPG_BORDER_EN.
- Defined: pixels with h=0, h=H_ACTIVE-1, v=0 or v=V_ACTIVE-1 output FFFFFF, overriding every pattern. Timing is unchanged.
- Undefined: no border logic; pattern output is unmodified.

Decomposition:
- tpg_pkg holds:
  - typedef enum logic[1:0] tpg_pattern_e {TPG_BARS, TPG_RAMP, TPG_CHECK, TPG_SOLID}
  - localparam array BAR_COLORS[8] of 24-bit values
  - state enum {TPG_IDLE, TPG_RUN}
- One natural sub-module: tpg_timing, containing the h/v counters, FSM and dv/hs/vs/frame_start/line_end generation.
- video_tpg instantiates tpg_timing and adds the pattern datapath plus the output register stage.

Test Plan:
Small parameters for all scenarios: H 16/2/3/3 (H_TOTAL=24), V 4/1/2/1 (V_TOTAL=8), HS_POL=VS_POL=1.
- Reset release, en_i=1 from cycle 0:
  - dv_o first high 2 edges later; dv_o high 16 clocks per line, 4 lines per frame.
  - hs_o high 3 clocks, starting 2 clocks after dv_o falls; vs_o high for 48 clocks (lines 5-6).
  - Frame period is 192 clocks.
- pattern_i=0: line 0 pixels 0-15 are FFFFFF x2, FFFF00 x2, 00FFFF x2, 00FF00 x2, FF00FF x2, FF0000 x2, 0000FF x2, 000000 x2.
  - rgb_o=0 during blanking; line_end_o single pulse per active line.
- pattern_i=3, solid=123456, then pattern_i switched to 1 mid-frame: rest of frame stays 123456; next frame pixel 5 = 050505.
- en_i dropped at line 1 of frame: frame completes (4 active lines, vs pulse), then busy_o=0 and all outputs sit at reset values.
- Async rst asserted mid-line during dv_o=1: outputs at reset values before the next edge.
  - On release with en_i=1, timing restarts from (0,0) and frame_start_o pulses on the first pixel.
- With TPG_BORDER_EN and pattern_i=2: line 0 all FFFFFF; line 1 pixels 0 and 15 FFFFFF, pixels 1-14 000000.
